reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 16 +
 rtl/reg_file_read_port.sv | 41 ++++
 rtl/reg_file.sv | 65 ++++++
 tb/tb_reg_file.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults, zero-register index and data/address typedefs for the register file.
package reg_file_pkg;

   localparam int unsigned DATA_WIDTH_DEFAULT = 64;
   localparam int unsigned ADDR_WIDTH_DEFAULT = 5;
   localparam int unsigned ZERO_REG           = 31;

   typedef logic [DATA_WIDTH_DEFAULT-1:0] reg_data_t;
   typedef logic [ADDR_WIDTH_DEFAULT-1:0] reg_addr_t;

   // The zero register is always the highest index, whatever the address width.
   function automatic int unsigned zero_reg_of(input int unsigned addr_width);
      return (32'd1 << addr_width) - 32'd1;
   endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: address decode, zero-register masking and, with
// REG_FILE_BYPASS_EN defined, a write-through bypass from the write port.
module reg_file_read_port
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
   input  logic                  reset,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] reg_write_dest,
   input  logic [DATA_WIDTH-1:0] reg_write_data,
   input  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH],
   input  logic [ADDR_WIDTH-1:0] read_addr,
   output logic [DATA_WIDTH-1:0] read_data
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(zero_reg_of(ADDR_WIDTH));

`ifdef REG_FILE_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = reg_write && !reset && (read_addr == reg_write_dest);
`else
   logic unused_bypass;
   assign unused_bypass = ^{reset, reg_write, reg_write_dest, reg_write_data};
`endif

   always_comb begin
      read_data = mem[read_addr];
`ifdef REG_FILE_BYPASS_EN
      if (bypass_hit) begin
         read_data = reg_write_data;
      end
`endif
      // Masking last so the zero register wins over any bypass.
      if (read_addr == ZERO_ADDR) begin
         read_data = '0;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with a hard-wired zero register (highest index).
// Optional write-through bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reg_write,
   input  logic [ADDR_WIDTH-1:0] reg_write_dest,
   input  logic [ADDR_WIDTH-1:0] reg_read_addr_1,
   input  logic [ADDR_WIDTH-1:0] reg_read_addr_2,
   input  logic [DATA_WIDTH-1:0] reg_write_data,
   output logic [DATA_WIDTH-1:0] reg_read_data_1,
   output logic [DATA_WIDTH-1:0] reg_read_data_2
);

   localparam int unsigned           DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(zero_reg_of(ADDR_WIDTH));

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic                  wr_en;

   // The zero register is never written, so its storage stays at its reset value.
   assign wr_en = reg_write && (reg_write_dest != ZERO_ADDR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[reg_write_dest] <= reg_write_data;
      end
   end

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_read_port_1 (
      .reset          (reset),
      .reg_write      (reg_write),
      .reg_write_dest (reg_write_dest),
      .reg_write_data (reg_write_data),
      .mem            (mem_q),
      .read_addr      (reg_read_addr_1),
      .read_data      (reg_read_data_1)
   );

   reg_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_read_port_2 (
      .reset          (reset),
      .reg_write      (reg_write),
      .reg_write_dest (reg_write_dest),
      .reg_write_data (reg_write_data),
      .mem            (mem_q),
      .read_addr      (reg_read_addr_2),
      .read_data      (reg_read_data_2)
   );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: array model checked every negedge plus directed
// literal checks; honours REG_FILE_BYPASS_EN like the design.
module tb_reg_file;
   import reg_file_pkg::*;

`ifdef REG_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        reg_write = 1'b0;
   logic [4:0]  reg_write_dest = '0;
   logic [4:0]  reg_read_addr_1 = '0;
   logic [4:0]  reg_read_addr_2 = '0;
   logic [63:0] reg_write_data = '0;
   logic [63:0] reg_read_data_1;
   logic [63:0] reg_read_data_2;

   logic [63:0] model_mem [32];
   bit          chk_en = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   reg_file dut (
      .clk             (clk),
      .reset           (reset),
      .reg_write       (reg_write),
      .reg_write_dest  (reg_write_dest),
      .reg_read_addr_1 (reg_read_addr_1),
      .reg_read_addr_2 (reg_read_addr_2),
      .reg_write_data  (reg_write_data),
      .reg_read_data_1 (reg_read_data_1),
      .reg_read_data_2 (reg_read_data_2)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
      $fatal(1, "watchdog");
   end

   // Model: plain array, cleared on reset, written on clk edges outside reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model_mem[i] <= '0;
      end else if (reg_write && reg_write_dest != 5'(ZERO_REG)) begin
         model_mem[reg_write_dest] <= reg_write_data;
      end
   end

   function automatic logic [63:0] model_read(input logic [4:0] addr);
      if (reset || addr == 5'(ZERO_REG)) return 64'h0;
      if (BYPASS && reg_write && addr == reg_write_dest) return reg_write_data;
      return model_mem[addr];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_rd1", reg_read_data_1, model_read(reg_read_addr_1));
         check("model_rd2", reg_read_data_2, model_read(reg_read_addr_2));
      end
   end

   // Advance to 2 time units after the next rising edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [4:0] dest, input logic [63:0] data);
      reg_write = 1'b1;
      reg_write_dest = dest;
      reg_write_data = data;
      step();
      reg_write = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      chk_en = 1'b1;

      // Reset state
      reg_read_addr_1 = 5'd6;
      reg_read_addr_2 = 5'd5;
      #1;
      check("reset_rd6", reg_read_data_1, 64'h0);
      check("reset_rd5", reg_read_data_2, 64'h0);
      step();

      // Basic write: reg 7 <= 0x394
      reg_read_addr_1 = 5'd7;
      reg_read_addr_2 = 5'd6;
      wr(5'd7, 64'h394);
      #1;
      check("wr7_rd7", reg_read_data_1, 64'h394);
      check("wr7_rd6", reg_read_data_2, 64'h0);
      step();

      // Zero register ignores writes
      reg_read_addr_1 = 5'd31;
      reg_read_addr_2 = 5'd31;
      reg_write = 1'b1;
      reg_write_dest = 5'd31;
      reg_write_data = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      check("zero_pre_rd1", reg_read_data_1, 64'h0);
      step();
      reg_write = 1'b0;
      #1;
      check("zero_rd1", reg_read_data_1, 64'h0);
      check("zero_rd2", reg_read_data_2, 64'h0);
      step();

      // Disabled write leaves reg 3 alone
      wr(5'd3, 64'h55);
      reg_read_addr_1 = 5'd3;
      reg_write = 1'b0;
      reg_write_dest = 5'd3;
      reg_write_data = 64'h1234;
      step();
      #1;
      check("nowr_rd3", reg_read_data_1, 64'h55);

      // Same-cycle read/write of reg 9
      reg_read_addr_1 = 5'd9;
      reg_read_addr_2 = 5'd9;
      reg_write = 1'b1;
      reg_write_dest = 5'd9;
      reg_write_data = 64'hAB;
      #1;
      check("rw9_pre", reg_read_data_1, BYPASS ? 64'hAB : 64'h0);
      step();
      reg_write = 1'b0;
      #1;
      check("rw9_post_p1", reg_read_data_1, 64'hAB);
      check("rw9_post_p2", reg_read_data_2, 64'hAB);

      // Distinct values on both ports, other write in flight
      wr(5'd0, 64'hDEAD_BEEF_0123_4567);
      reg_read_addr_1 = 5'd0;
      reg_read_addr_2 = 5'd7;
      reg_write = 1'b1;
      reg_write_dest = 5'd30;
      reg_write_data = 64'h8000_0000_0000_0001;
      #1;
      check("p1_reg0", reg_read_data_1, 64'hDEAD_BEEF_0123_4567);
      check("p2_reg7", reg_read_data_2, 64'h394);
      step();
      reg_write = 1'b0;
      reg_read_addr_2 = 5'd30;
      #1;
      check("p2_reg30", reg_read_data_2, 64'h8000_0000_0000_0001);
      step();

      // Mid-operation reset between edges
      for (int i = 1; i <= 4; i++) wr(5'(i), 64'h1111 * 64'(i));
      reg_read_addr_1 = 5'd2;
      reg_read_addr_2 = 5'd4;
      #1;
      check("load_rd2", reg_read_data_1, 64'h2222);
      check("load_rd4", reg_read_data_2, 64'h4444);
      reset = 1'b1;
      #1;
      check("midrst_rd2", reg_read_data_1, 64'h0);
      check("midrst_rd4", reg_read_data_2, 64'h0);

      // Write attempted on an edge while reset is held
      reg_write = 1'b1;
      reg_write_dest = 5'd2;
      reg_write_data = 64'h77;
      reg_read_addr_1 = 5'd2;
      #1;
      check("rst_bypass_blk", reg_read_data_1, 64'h0);
      step();
      reg_write = 1'b0;
      reset = 1'b0;
      #1;
      check("rst_wr_blocked", reg_read_data_1, 64'h0);
      reg_read_addr_1 = 5'd1;
      reg_read_addr_2 = 5'd3;
      #1;
      check("rst_rd1", reg_read_data_1, 64'h0);
      check("rst_rd3", reg_read_data_2, 64'h0);

      // First edge after reset release writes
      wr(5'd2, 64'h99);
      reg_read_addr_1 = 5'd2;
      #1;
      check("post_rst_wr", reg_read_data_1, 64'h99);
      step();
      step();

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
